// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: async serial frame receiver driving an external bit-period timer.
// Optional even-parity stage is enabled by defining PARITY_CHECK_EN.
module rx_frame_ctrl #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 sample_strobe,
  input  logic                 data_read,
  output logic                 timer_enable,
  output logic                 timer_sync,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun,
  output logic                 framing_error,
  output logic                 parity_error
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
`ifdef PARITY_CHECK_EN
    PARITY,
`endif
    STOP,
    LOAD
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_q, stop_d;
  logic                 sync1_q, s_cur_q, s_prev_q;
  logic                 timer_enable_q, timer_sync_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 data_ready_q, overrun_q, framing_error_q;
  logic                 fall_c, fall_next_c, frame_ok_c, parity_ok_c;

  // Falling edge on the synchronised line now, and the one that will be seen next cycle
  assign fall_c      = s_prev_q & ~s_cur_q;
  assign fall_next_c = s_cur_q & ~sync1_q;

`ifdef PARITY_CHECK_EN
  logic parity_q, parity_d, parity_error_q;
  assign parity_ok_c  = ~(^{shift_q, parity_q});
  assign parity_error = parity_error_q;
`else
  assign parity_ok_c  = 1'b1;
  assign parity_error = 1'b0;
`endif

  assign frame_ok_c = stop_q & parity_ok_c;

  // Two-flop synchroniser plus one delay flop for edge detection; idle line is high
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q  <= 1'b1;
      s_cur_q  <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      sync1_q  <= serial_in;
      s_cur_q  <= sync1_q;
      s_prev_q <= s_cur_q;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      stop_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      stop_q    <= stop_d;
`ifdef PARITY_CHECK_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic: strobes only matter between START_CHK and STOP
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    stop_d    = stop_q;
`ifdef PARITY_CHECK_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (fall_c) state_d = START_CHK;
      end
      START_CHK: begin
        if (sample_strobe) begin
          if (!s_cur_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (sample_strobe) begin
          shift_d = {s_cur_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (sample_strobe) begin
          parity_d = s_cur_q;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (sample_strobe) begin
          stop_d  = s_cur_q;
          state_d = LOAD;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timer controls registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer_enable_q <= 1'b0;
      timer_sync_q   <= 1'b0;
    end else begin
      timer_enable_q <= (state_d != IDLE) && (state_d != LOAD);
      timer_sync_q   <= (state_d == LOAD) || ((state_d == IDLE) && fall_next_c);
    end
  end

  // Host-visible word and status; a good load takes priority over a same-cycle data_read
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data_q       <= '0;
      data_ready_q    <= 1'b0;
      overrun_q       <= 1'b0;
      framing_error_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_error_q  <= 1'b0;
`endif
    end else begin
      if (state_q == LOAD) begin
        framing_error_q <= ~stop_q;
`ifdef PARITY_CHECK_EN
        parity_error_q  <= ~parity_ok_c;
`endif
      end
      if ((state_q == LOAD) && frame_ok_c) begin
        rx_data_q    <= shift_q;
        data_ready_q <= 1'b1;
        overrun_q    <= overrun_q | (data_ready_q & ~data_read);
      end else if (data_read && data_ready_q) begin
        data_ready_q <= 1'b0;
        overrun_q    <= 1'b0;
      end
    end
  end

  assign timer_enable  = timer_enable_q;
  assign timer_sync    = timer_sync_q;
  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign overrun       = overrun_q;
  assign framing_error = framing_error_q;

endmodule
